// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU bundle for alu_share_arbiter.
// With ALU_ARB_ZFLAG_EN defined the response side also carries rsp_zero.
interface alu_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int IDXW  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_ip1;
  logic [NREQ*WIDTH-1:0] req_ip2;
  logic [NREQ*OPW-1:0]   req_opcode;
  logic [WIDTH-1:0]      alu_ip1;
  logic [WIDTH-1:0]      alu_ip2;
  logic [OPW-1:0]        alu_opcode;
  logic [WIDTH-1:0]      alu_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDXW-1:0]       rsp_idx;
  logic [7:0]            op_count;
`ifdef ALU_ARB_ZFLAG_EN
  logic                  rsp_zero;
`endif

  modport slave (
    input  req_valid, req_ip1, req_ip2, req_opcode, alu_op, rsp_ready,
    output req_ready, alu_ip1, alu_ip2, alu_opcode, rsp_valid, rsp_data, rsp_idx, op_count
`ifdef ALU_ARB_ZFLAG_EN
    , output rsp_zero
`endif
  );

  modport master (
    output req_valid, req_ip1, req_ip2, req_opcode, alu_op, rsp_ready,
    input  req_ready, alu_ip1, alu_ip2, alu_opcode, rsp_valid, rsp_data, rsp_idx, op_count
`ifdef ALU_ARB_ZFLAG_EN
    , input rsp_zero
`endif
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one external combinational ALU between NREQ requesters.
// Define ALU_ARB_ZFLAG_EN to add rsp_zero, a registered (result == 0) flag held with rsp_data.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int IDXW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] { IDLE, LOAD, EXEC, RESP } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  rr_ptr_q;
  logic [WIDTH-1:0] alu_ip1_q;
  logic [WIDTH-1:0] alu_ip2_q;
  logic [OPW-1:0]   alu_opcode_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDXW-1:0]  rsp_idx_q;
  logic [7:0]       op_count_q;
`ifdef ALU_ARB_ZFLAG_EN
  logic             rsp_zero_q;
`endif

  logic             grant_any_d;
  logic [IDXW-1:0]  grant_idx_d;

  logic [WIDTH-1:0] ip1_arr [NREQ];
  logic [WIDTH-1:0] ip2_arr [NREQ];
  logic [OPW-1:0]   opc_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ip1_arr[i] = bus.req_ip1[i*WIDTH +: WIDTH];
    assign ip2_arr[i] = bus.req_ip2[i*WIDTH +: WIDTH];
    assign opc_arr[i] = bus.req_opcode[i*OPW +: OPW];
  end

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum -= NREQ;
    return IDXW'(sum);
  endfunction

  // Scan from the furthest offset back towards rr_ptr so the nearest valid requester wins.
  // Grants are suppressed while rst is high so nothing is offered during reset.
  always_comb begin
    logic [IDXW-1:0] cand;
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    grant_any_d = 1'b0;
    grant_idx_d = '0;
    cand        = '0;
    if (state_q == IDLE && !rst) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = wrap_add(rr_ptr_q, k);
        if (bus.req_valid[cand]) begin
          grant_any_d = 1'b1;
          grant_idx_d = cand;
        end
      end
    end
  end

  assign bus.req_ready = grant_any_d ? (NREQ'(1) << grant_idx_d) : '0;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      alu_ip1_q    <= '0;
      alu_ip2_q    <= '0;
      alu_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_idx_q    <= '0;
      op_count_q   <= '0;
`ifdef ALU_ARB_ZFLAG_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            alu_ip1_q    <= ip1_arr[grant_idx_d];
            alu_ip2_q    <= ip2_arr[grant_idx_d];
            alu_opcode_q <= opc_arr[grant_idx_d];
            rsp_idx_q    <= grant_idx_d;
            rr_ptr_q     <= wrap_add(grant_idx_d, 1);
            state_q      <= LOAD;
          end
        end
        LOAD: state_q <= EXEC;
        EXEC: begin
          rsp_data_q  <= bus.alu_op;
`ifdef ALU_ARB_ZFLAG_EN
          rsp_zero_q  <= (bus.alu_op == '0);
`endif
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_ip1    = alu_ip1_q;
  assign bus.alu_ip2    = alu_ip2_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_idx    = rsp_idx_q;
  assign bus.op_count   = op_count_q;
`ifdef ALU_ARB_ZFLAG_EN
  assign bus.rsp_zero   = rsp_zero_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a transaction-level model predicts grants and results,
// a separate monitor compares every presented response. Build with ALU_ARB_ZFLAG_EN to cover rsp_zero.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 4;
  localparam int OPW      = 3;
  localparam int IDXW     = 2;
  localparam int MAX_WAIT = 200;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [IDXW-1:0]  idx;
    logic             zero;
    int               hs_cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .IDXW(IDXW)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH-1:0] ip1_a [NREQ];
  logic [WIDTH-1:0] ip2_a [NREQ];
  logic [OPW-1:0]   opc_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_ip1[i*WIDTH +: WIDTH]  = ip1_a[i];
    assign bus.req_ip2[i*WIDTH +: WIDTH]  = ip2_a[i];
    assign bus.req_opcode[i*OPW +: OPW]   = opc_a[i];
  end

  // Stand-in for the shared lab ALU: 8 functions, results truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [OPW-1:0] opc,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (opc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always_comb bus.alu_op = alu_ref(bus.alu_opcode, bus.alu_ip1, bus.alu_ip2);

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  exp_t exp_q[$];
  int   grant_log[$];

  logic [7:0]               exp_count = '0;
  logic                     busy = 1'b0;
  logic                     pend_hs = 1'b0;
  logic                     release_pending = 1'b0;
  int                       rr = 0;
  int                       hs_count = 0;
  logic [OPW+2*WIDTH-1:0]   exp_alu = '0;
  logic [OPW+2*WIDTH-1:0]   pend_alu = '0;
  logic [WIDTH-1:0]         last_data = '0;
  logic [IDXW-1:0]          last_idx = '0;
  logic                     last_zero = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic reset_model();
    busy            = 1'b0;
    pend_hs         = 1'b0;
    release_pending = 1'b0;
    rr              = 0;
    exp_alu         = '0;
    exp_q.delete();
  endtask

  task automatic drive(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      ip1_a[i] = WIDTH'($urandom);
      ip2_a[i] = WIDTH'($urandom);
      opc_a[i] = OPW'($urandom);
    end
    bus.req_valid = v;
  endtask

  // One clock: predict and check the coming edge at the negedge, apply model updates just after it.
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    logic [IDXW-1:0] gi;
    exp_t            e;
    int              g;
    @(negedge clk);
    if (!rst) begin
      g = -1;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx = (rr + k) % NREQ;
          if (g < 0 && bus.req_valid[IDXW'(idx)]) g = idx;
        end
      end
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("alu_bus", 32'({bus.alu_opcode, bus.alu_ip1, bus.alu_ip2}), 32'(exp_alu));
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[IDXW'(i)]) grant_log.push_back(i);
      if (g >= 0) begin
        gi         = IDXW'(g);
        e.data     = alu_ref(opc_a[gi], ip1_a[gi], ip2_a[gi]);
        e.idx      = gi;
        e.zero     = (e.data == '0);
        e.hs_cycle = cycle + 1;
        exp_q.push_back(e);
        pend_alu   = {opc_a[gi], ip1_a[gi], ip2_a[gi]};
        pend_hs    = 1'b1;
        rr         = (g + 1) % NREQ;
        busy       = 1'b1;
        hs_count++;
      end
    end
    @(posedge clk);
    #1;
    if (pend_hs) begin
      exp_alu = pend_alu;
      pend_hs = 1'b0;
    end
    if (release_pending) begin
      busy            = 1'b0;
      release_pending = 1'b0;
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    reset_model();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < MAX_WAIT) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'({busy, exp_q.size() != 0}), 32'(0));
  endtask

  // Monitor: compares whatever the DUT presents against the head of the expectation queue.
  initial begin : monitor
    logic held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_count = '0;
        held      = 1'b0;
      end else begin
        check("op_count", 32'(bus.op_count), 32'(exp_count));
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
          end else begin
            if (!held) check("rsp_latency", 32'(cycle), 32'(exp_q[0].hs_cycle + 2));
            check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
            check("rsp_idx", 32'(bus.rsp_idx), 32'(exp_q[0].idx));
`ifdef ALU_ARB_ZFLAG_EN
            check("rsp_zero", 32'(bus.rsp_zero), 32'(exp_q[0].zero));
`endif
            if (bus.rsp_ready) begin
              last_data = bus.rsp_data;
              last_idx  = bus.rsp_idx;
`ifdef ALU_ARB_ZFLAG_EN
              last_zero = bus.rsp_zero;
`endif
              void'(exp_q.pop_front());
              exp_count       = exp_count + 8'd1;
              release_pending = 1'b1;
            end
          end
        end
        held = bus.rsp_valid && !bus.rsp_ready;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] start_cnt;
    int         target;
    int         n;
    int         log_size;

    // Reset with every requester asserting valid.
    rst           = 1'b1;
    bus.rsp_ready = 1'b0;
    drive('1);
    reset_model();
    repeat (2) tick();
    check("reset_req_ready", 32'(bus.req_ready), 32'(0));
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("reset_op_count", 32'(bus.op_count), 32'(0));
    check("reset_alu_bus", 32'({bus.alu_opcode, bus.alu_ip1, bus.alu_ip2}), 32'(0));

    // Single op from requester 0: 3 + 5.
    drive(4'b0001);
    ip1_a[0] = 4'h3; ip2_a[0] = 4'h5; opc_a[0] = 3'b000;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("single_data", 32'(last_data), 32'(4'h8));
    check("single_idx", 32'(last_idx), 32'(0));
    check("single_count", 32'(bus.op_count), 32'(1));

    // Fairness: all valid, opcode 001, starting from a fresh rr pointer.
    bus.req_valid = '0;
    apply_reset(2);
    grant_log.delete();
    drive('1);
    for (int i = 0; i < NREQ; i++) opc_a[i] = 3'b001;
    n = 0;
    while (grant_log.size() < 5 && n < MAX_WAIT) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    check("fair_grants", 32'(grant_log.size()), 32'(5));
    if (grant_log.size() >= 5) begin
      check("fair_g0", 32'(grant_log[0]), 32'(0));
      check("fair_g1", 32'(grant_log[1]), 32'(1));
      check("fair_g2", 32'(grant_log[2]), 32'(2));
      check("fair_g3", 32'(grant_log[3]), 32'(3));
      check("fair_g4", 32'(grant_log[4]), 32'(0));
    end
    check("fair_count", 32'(bus.op_count), 32'(5));

    // Back-pressure: response held for 10 cycles while everyone else keeps requesting.
    bus.rsp_ready = 1'b0;
    drive(4'b0100);
    tick();
    bus.req_valid = '1;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
    end
    log_size = grant_log.size();
    repeat (10) tick();
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("bp_no_grant", 32'(grant_log.size()), 32'(log_size));
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("bp_idx", 32'(last_idx), 32'(2));

    // Overflow: F + 1 wraps to 0.
    drive(4'b0010);
    ip1_a[1] = 4'hF; ip2_a[1] = 4'h1; opc_a[1] = 3'b000;
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("ovf_data", 32'(last_data), 32'(0));
`ifdef ALU_ARB_ZFLAG_EN
    check("ovf_zero", 32'(last_zero), 32'(1));
`endif

    // 256 further ops bring op_count back to its starting value.
    start_cnt = exp_count;
    target    = hs_count + 256;
    n = 0;
    while (hs_count < target && n < 5000) begin
      drive(NREQ'($urandom_range(15, 0)));
      tick();
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    check("wrap_ops", 32'(hs_count), 32'(target));
    check("wrap_count", 32'(bus.op_count), 32'(start_cnt));

    // Random traffic with dropped valids and random back-pressure.
    for (int c = 0; c < 400; c++) begin
      drive(NREQ'($urandom_range(15, 0)));
      bus.rsp_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Reset while the op is in EXEC: it is dropped and arbitration restarts at index 0.
    drive(4'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    apply_reset(2);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("midrst_op_count", 32'(bus.op_count), 32'(0));
    drive(4'b1010);
    tick();
    bus.req_valid = '0;
    check("midrst_grant", 32'(grant_log[grant_log.size()-1]), 32'(1));
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
